mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_byte_array.sv | 32 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder shared definitions.
// Size codes, responder states and the alignment check.
package mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reserved size and unaligned halfword/word accesses fault.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between requester and responder.
// master drives requests, slave answers.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_array.sv
// Byte-addressed storage, 4-lane byte-enable write port.
// Read returns 4 bytes from base address, little-endian.
module mem_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Lane i lands on byte addr+i when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = {mem[addr + ADDR_W'(3)],
                    mem[addr + ADDR_W'(2)],
                    mem[addr + ADDR_W'(1)],
                    mem[addr]};

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder, fixed latency.
// Owns FSM, latency counter, fault checks and lane steering.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        c_we;
    logic [1:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;

    logic        accept;
    logic        a_we;
    logic [1:0]  a_size;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_err;
    logic        do_access;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] rd_raw;
    logic [31:0] rd_data;
    logic [31:0] rsp_d;

    assign accept = (state == IDLE) && bus.req_valid && ready_q;

    // With LATENCY 1 the access happens on the accept edge,
    // so the live request is used instead of the captured one.
    assign a_we    = (state == IDLE) ? bus.req_we    : c_we;
    assign a_size  = (state == IDLE) ? bus.req_size  : c_size;
    assign a_addr  = (state == IDLE) ? bus.req_addr  : c_addr;
    assign a_wdata = (state == IDLE) ? bus.req_wdata : c_wdata;

    assign a_err = ((a_addr >> ADDR_W) != 32'd0)
                 || misaligned(a_size, a_addr[1:0]);

    assign do_access = (LATENCY == 1) ? accept
                     : ((state == BUSY) && (cnt == 4'd0));

    assign mem_we = do_access && a_we && !a_err && !reset;

    // Lane enables and zero-extended read data per size.
    always_comb begin
        be      = 4'b0000;
        rd_data = 32'd0;
        case (a_size)
            SZ_BYTE: begin
                be      = 4'b0001;
                rd_data = {24'd0, rd_raw[7:0]};
            end
            SZ_HALF: begin
                be      = 4'b0011;
                rd_data = {16'd0, rd_raw[15:0]};
            end
            SZ_WORD: begin
                be      = 4'b1111;
                rd_data = rd_raw;
            end
            default: begin
                be      = 4'b0000;
                rd_data = 32'd0;
            end
        endcase
    end

    assign rsp_d = (a_we || a_err) ? 32'd0 : rd_data;

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (be),
        .addr  (a_addr[ADDR_W-1:0]),
        .wdata (a_wdata),
        .rdata (rd_raw)
    );

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (do_access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= a_err;
                rsp_rdata_q <= rsp_d;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        c_we    <= bus.req_we;
                        c_size  <= bus.req_size;
                        c_addr  <= bus.req_addr;
                        c_wdata <= bus.req_wdata;
                        cnt     <= 4'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state   <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed plan plus random traffic
// against a byte-array reference model.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(
        .ADDR_W  (8),
        .LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:255];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [1:0] size,
                                     input logic [31:0] addr);
        if (addr >= 32'd256) return 1'b1;
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] size,
                                               input logic [31:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < (1 << size); i++)
            v = v | (32'(ref_mem[addr + i]) << (8 * i));
        return v;
    endfunction

    task automatic model_write(input logic [1:0] size,
                               input logic [31:0] addr,
                               input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++)
            ref_mem[addr + i] = wdata[8*i +: 8];
    endtask

    task automatic run_req(input string tag,
                           input logic we,
                           input logic [1:0] size,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic [31:0] got_d,
                           output logic got_e);
        logic        exp_e;
        logic [31:0] exp_d;
        int          waited;
        int          lat;
        exp_e = model_err(size, addr);
        exp_d = (we || exp_e) ? 32'd0 : model_read(size, addr);
        @(negedge clk);
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 10);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
        check({tag, "_data"}, bus.rsp_rdata, exp_d);
        got_d = bus.rsp_rdata;
        got_e = bus.rsp_err;
        if (we && !exp_e) model_write(size, addr, wdata);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_hold"}, bus.rsp_rdata, exp_d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          nrsp;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] ad;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_req("w1", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, d, e);
        run_req("r1", 1'b0, 2'd2, 32'h10, 32'h0, d, e);
        check("r1_const", d, 32'hDEADBEEF);
        run_req("wb", 1'b1, 2'd0, 32'h11, 32'hAA, d, e);
        run_req("r2", 1'b0, 2'd2, 32'h10, 32'h0, d, e);
        check("r2_const", d, 32'hDEADAAEF);
        run_req("rh", 1'b0, 2'd1, 32'h12, 32'h0, d, e);
        check("rh_const", d, 32'h0000DEAD);
        run_req("rb", 1'b0, 2'd0, 32'h13, 32'h0, d, e);
        check("rb_const", d, 32'h000000DE);
        run_req("rmis", 1'b0, 2'd2, 32'h11, 32'h0, d, e);
        check("rmis_const", {31'd0, e}, 32'd1);
        run_req("wmis", 1'b1, 2'd2, 32'h12, 32'h0, d, e);
        check("wmis_const", {31'd0, e}, 32'd1);
        run_req("r3", 1'b0, 2'd2, 32'h10, 32'h0, d, e);
        check("r3_const", d, 32'hDEADAAEF);
        run_req("rrange", 1'b0, 2'd0, 32'h100, 32'h0, d, e);
        check("rrange_const", {31'd0, e}, 32'd1);
        run_req("rsz3", 1'b0, 2'd3, 32'h10, 32'h0, d, e);

        @(negedge clk);
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h10;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        nrsp = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) nrsp++;
            check($sformatf("hold_ready%0d", k), {31'd0, bus.req_ready},
                  (k == 3) ? 32'd1 : 32'd0);
        end
        check("hold_nrsp", nrsp, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hold2_early", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("hold2_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("hold2_data", bus.rsp_rdata, 32'hDEADAAEF);
        @(posedge clk);

        run_req("wz", 1'b1, 2'd2, 32'h20, 32'h0, d, e);
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mrst_ready", {31'd0, bus.req_ready}, 32'd1);
        nrsp = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.rsp_valid === 1'b1) nrsp++;
            @(posedge clk);
            #1;
        end
        check("mrst_nrsp", nrsp, 0);
        run_req("rz", 1'b0, 2'd2, 32'h20, 32'h0, d, e);
        check("rz_const", d, 32'h0);

        for (int a = 32'h40; a < 32'h80; a += 4)
            run_req("init", 1'b1, 2'd2, 32'(a), $urandom, d, e);

        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom % 2);
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            ad = 32'h40 + ($urandom % 64);
            if ($urandom % 8 == 0) ad = ad | (32'h100 << ($urandom % 24));
            run_req($sformatf("rnd%0d", n), we, sz, ad, $urandom, d, e);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
